// File: rtl/robertson_pkg.sv
// robertson_pkg: state encoding, counter sizing and shift-mode constants shared
// by the Robertson multiplier control, datapath and shift register wrapper.
package robertson_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, TEST, ADD, SHIFT, DONE} state_t;
    localparam logic SHIFT_ARITH = 1'b0;
    localparam logic SHIFT_LOGIC = 1'b1;
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/iter_counter.sv
// iter_counter: loadable down-counter that saturates at zero.
module iter_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (load) count <= load_val;
        else if (dec && !zero) count <= count - 1'b1;
    end
    assign zero = (count == '0);
endmodule

// File: rtl/robertson_control.sv
// robertson_control: sequences test/add/shift iterations of a Robertson
// signed/unsigned shift-add multiplier, one iteration per multiplier bit.
module robertson_control
    import robertson_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic signed_op,
    input  logic q_lsb,
    output logic load_regs,
    output logic add_en,
    output logic sub,
    output logic shift_en,
    output logic shift_mode,
    output logic busy,
    output logic done
);
    localparam int CNT_W = cnt_w(WIDTH);
    state_t state, next;
    logic sgn_q;
    logic zero;
    logic [CNT_W-1:0] count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sgn_q <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && start) sgn_q <= signed_op;
        end
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:  next = start ? LOAD : IDLE;
            LOAD:  next = TEST;
            TEST:  next = q_lsb ? ADD : SHIFT;
            ADD:   next = SHIFT;
            SHIFT: next = zero ? DONE : TEST;
            DONE:  next = IDLE;
            default: next = IDLE;
        endcase
        load_regs  = (state == LOAD);
        add_en     = (state == ADD);
        // Final iteration tests the multiplier sign bit, which carries negative weight
        sub        = (state == ADD) && sgn_q && zero;
        shift_en   = (state == SHIFT);
        shift_mode = sgn_q ? SHIFT_ARITH : SHIFT_LOGIC;
        busy       = (state != IDLE);
        done       = (state == DONE);
    end
    iter_counter #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == LOAD),
        .dec     (state == SHIFT),
        .load_val(CNT_W'(WIDTH - 1)),
        .count   (count),
        .zero    (zero)
    );
endmodule
